// File: rtl/uvmt_clk_st_pkg.sv
// Shared types and constants for the clock-agent self-test divider.
package uvmt_clk_st_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } uvmt_clk_st_div_state_t;

  localparam int UVMT_CLK_ST_MIN_DIV_RATIO = 2;

endpackage

// File: rtl/uvmt_clk_st_clk_div.sv
// Programmable integer clock divider: glitch-free registered clk_out, ratio
// changes through a valid/ready handshake applied only on period boundaries.
module uvmt_clk_st_clk_div
  import uvmt_clk_st_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int DEFAULT_RATIO = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             active
);

  localparam logic [CNT_W-1:0] MIN_RATIO   = CNT_W'(UVMT_CLK_ST_MIN_DIV_RATIO);
  localparam logic [CNT_W-1:0] RESET_RATIO = CNT_W'(DEFAULT_RATIO);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  uvmt_clk_st_div_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] ratio_reg, ratio_next;
  logic [CNT_W-1:0] pend_reg, pend_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             clk_out_reg, clk_out_next;
  logic             rise_reg, rise_next;
  logic             accept;
  logic             wrap;
  logic [CNT_W-1:0] ratio_clamped;

  assign cfg_ready     = !pend_valid_reg;
  assign accept        = cfg_valid && cfg_ready;
  assign cfg_err       = accept && (cfg_ratio < MIN_RATIO);
  assign ratio_clamped = (cfg_ratio < MIN_RATIO) ? MIN_RATIO : cfg_ratio;
  assign wrap          = (cnt_reg == (ratio_reg - ONE));

  assign clk_out    = clk_out_reg;
  assign rise_pulse = rise_reg;
  assign active     = (state_reg != IDLE);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    ratio_next      = ratio_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;

    unique case (state_reg)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        if (!en) state_next = STOPPING;
      end
      STOPPING: begin
        if (en)        state_next = RUN;
        else if (wrap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Idle holds the counter and takes a pending ratio immediately; while
    // running, the ratio may only change at the period wrap.
    if (state_reg == IDLE) begin
      cnt_next = '0;
      if (pend_valid_reg) begin
        ratio_next      = pend_reg;
        pend_valid_next = 1'b0;
      end
    end else if (wrap) begin
      cnt_next = '0;
      if (pend_valid_reg) begin
        ratio_next      = pend_reg;
        pend_valid_next = 1'b0;
      end
    end else begin
      cnt_next = cnt_reg + ONE;
    end

    if (accept) begin
      pend_next       = ratio_clamped;
      pend_valid_next = 1'b1;
    end

    // Output phase is computed from the post-edge count and ratio so that
    // clk_out is a pure flop with the high phase first in every period.
    clk_out_next = (state_next != IDLE) && (cnt_next < (ratio_next >> 1));
    rise_next    = clk_out_next && !clk_out_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      ratio_reg      <= RESET_RATIO;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      clk_out_reg    <= 1'b0;
      rise_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      ratio_reg      <= ratio_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      clk_out_reg    <= clk_out_next;
      rise_reg       <= rise_next;
    end
  end

endmodule

// File: tb/tb_uvmt_clk_st_clk_div.sv
// Self-checking bench for uvmt_clk_st_clk_div: period-level reference model,
// expected outputs queued per cycle, rise events scoreboarded separately.
module tb_uvmt_clk_st_clk_div;

  localparam int CNT_W = 8;
  localparam int DEF_N = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_ratio = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             rise_pulse;
  logic             active;

  uvmt_clk_st_clk_div #(.CNT_W(CNT_W), .DEFAULT_RATIO(DEF_N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ratio  (cfg_ratio),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse),
    .active     (active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic clk_out;
    logic rise;
    logic active;
    logic ready;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  int   rise_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a period in progress, position inside it, current and
  // pending ratio, and whether a stop has been requested.
  int m_n, m_pend, m_pos;
  bit m_act, m_stop, m_pend_v;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m_n = DEF_N; m_pend = 0; m_pos = 0;
    m_act = 0; m_stop = 0; m_pend_v = 0;
  endtask

  task automatic model_edge(input logic e, input logic v, input logic [CNT_W-1:0] r);
    bit acc;
    acc = v && !m_pend_v;
    if (!m_act) begin
      if (m_pend_v) begin m_n = m_pend; m_pend_v = 0; end
      if (e) begin m_act = 1; m_pos = 0; m_stop = 0; end
    end else if (m_pos == m_n - 1) begin
      if (m_pend_v) begin m_n = m_pend; m_pend_v = 0; end
      m_pos = 0;
      if (m_stop && !e) m_act = 0;
      else              m_stop = !e;
    end else begin
      m_pos++;
      m_stop = !e;
    end
    if (acc) begin
      m_pend   = (r < 2) ? 2 : int'(r);
      m_pend_v = 1;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.cyc     = cyc;
    e.clk_out = m_act && (m_pos < m_n / 2);
    e.rise    = m_act && (m_pos == 0);
    e.active  = m_act;
    e.ready   = !m_pend_v;
    e.err     = cfg_valid && !m_pend_v && (cfg_ratio < 2);
    exp_q.push_back(e);
    if (e.rise) rise_q.push_back(cyc);
  endtask

  // Called at posedge+1: drive this cycle's inputs, record expectations,
  // advance the model through the coming edge.
  task automatic step(input logic e, input logic v, input logic [CNT_W-1:0] r);
    en = e; cfg_valid = v; cfg_ratio = r;
    push_exp();
    if (reset_n) model_edge(e, v, r);
    @(posedge clk); #1;
  endtask

  task automatic run_until(input int pos, input logic e, input int budget);
    int k = 0;
    while (!(m_act && m_pos == pos) && k < budget) begin
      step(e, 1'b0, '0);
      k++;
    end
    if (!(m_act && m_pos == pos)) begin
      n_cmp++; n_bad++;
      $display("FAIL run_until pos %0d: budget of %0d cycles expired", pos, budget);
    end
  endtask

  task automatic run_idle(input int budget);
    int k = 0;
    while (m_act && k < budget) begin
      step(1'b0, 1'b0, '0);
      k++;
    end
    if (m_act) begin
      n_cmp++; n_bad++;
      $display("FAIL run_idle: budget of %0d cycles expired", budget);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_ratio = '0;
    #1;
    chk("async_reset_clk_out", clk_out, 0);
    chk("async_reset_active", active, 0);
    chk("async_reset_ready", cfg_ready, 1);
    model_reset();
    push_exp();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  exp_t mon_e;
  int   mon_r;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("clk_out", clk_out, mon_e.clk_out);
      chk("rise_pulse", rise_pulse, mon_e.rise);
      chk("active", active, mon_e.active);
      chk("cfg_ready", cfg_ready, mon_e.ready);
      chk("cfg_err", cfg_err, mon_e.err);
    end
    if (rise_pulse === 1'b1) begin
      chk("rise_expected", rise_q.size() > 0, 1);
      if (rise_q.size() > 0) begin
        mon_r = rise_q.pop_front();
        chk("rise_cycle", cyc, mon_r);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0);

    // Default ratio start-up
    repeat (13) step(1'b1, 1'b0, '0);

    // Ratio 3 offered at cnt = 1
    run_until(1, 1'b1, 8);
    step(1'b1, 1'b1, 8'd3);
    repeat (14) step(1'b1, 1'b0, '0);

    // Ratio 1 offered in idle is clamped to 2
    run_idle(20);
    step(1'b0, 1'b1, 8'd1);
    repeat (3) step(1'b0, 1'b0, '0);
    repeat (8) step(1'b1, 1'b0, '0);

    // Back to 4, then offer 6 exactly in the wrap cycle
    step(1'b1, 1'b1, 8'd4);
    repeat (6) step(1'b1, 1'b0, '0);
    run_until(3, 1'b1, 16);
    step(1'b1, 1'b1, 8'd6);
    repeat (20) step(1'b1, 1'b0, '0);

    // Ratio 5: stop at cnt = 0, then re-assert during stopping
    step(1'b1, 1'b1, 8'd5);
    repeat (8) step(1'b1, 1'b0, '0);
    run_until(0, 1'b1, 16);
    step(1'b0, 1'b0, '0);
    run_idle(20);
    repeat (2) step(1'b0, 1'b0, '0);
    run_until(0, 1'b1, 16);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    repeat (12) step(1'b1, 1'b0, '0);

    // Reset in the high phase with a pending ratio
    run_until(0, 1'b1, 16);
    step(1'b1, 1'b1, 8'd9);
    do_reset();
    repeat (2) step(1'b0, 1'b0, '0);
    repeat (14) step(1'b1, 1'b0, '0);

    // Randomized traffic
    begin
      logic e_r;
      e_r = 1'b1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 19) == 0) e_r = ~e_r;
        step(e_r, ($urandom_range(0, 4) == 0), 8'($urandom_range(0, 10)));
      end
    end

    run_idle(40);
    repeat (3) step(1'b0, 1'b0, '0);
    @(negedge clk); #1;
    chk("rise_queue_drained", rise_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
